// File: rtl/surf_splice_pkg.sv
// Shared types and constants for the SURF event splicer.
package surf_splice_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        COUNT,
        PAD,
        HOLDOFF
    } state_t;

    localparam int ERR_OVF = 0;
    localparam int ERR_SAT = 1;
    localparam int ERR_TMO = 2;

    localparam FAKE_ZERO = "ZERO";
    localparam FAKE_RAMP = "RAMP";

    function automatic int nbytes(input int nch, input int bpc, input int hdr);
        return nch * bpc + hdr;
    endfunction

endpackage

// File: rtl/splice_fifo.sv
// Synchronous first-word-fall-through FIFO; writes while full are dropped and flagged.
module splice_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic         o_valid,
    output logic         o_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    logic w_full;
    logic w_push;
    logic w_pop;

    always_comb begin
        w_full    = (r_cnt == FULL_CNT);
        w_push    = i_wr_en && !w_full;
        o_valid   = (r_cnt != '0);
        w_pop     = i_rd_en && o_valid;
        o_ovf     = i_wr_en && w_full;
        o_rd_data = r_mem[r_rp];
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/surf_event_splice_gen.sv
// Frames SURF events into a buffered byte stream; synthesises equal-length fake
// events per trigger while the SURF is masked.
module surf_event_splice_gen
    import surf_splice_pkg::*;
#(
    parameter int NUM_CH       = 8,
    parameter int BYTES_PER_CH = 1536,
    parameter int HDR_BYTES    = 4,
    parameter int FIFO_DEPTH   = 16384,
    parameter int TRIG_W       = 4,
    parameter int HOLDOFF_W    = 24,
    parameter int TIMEOUT      = 1024,
    parameter     FAKE_MODE    = "RAMP"
) (
    input  logic                 aclk,
    input  logic                 rst,
    input  logic                 trig_i,
    input  logic                 mask_i,
    input  logic                 holdoff_ce_i,
    input  logic [HOLDOFF_W-1:0] rdholdoff_i,
    input  logic [7:0]           s_dout_tdata,
    input  logic                 s_dout_tvalid,
    output logic [7:0]           m_dout_tdata,
    output logic                 m_dout_tvalid,
    input  logic                 m_dout_tready,
    output logic                 m_dout_tlast,
    output logic                 m_dout_tuser,
    output logic [2:0]           err_o,
    input  logic                 err_clr_i,
    output logic [31:0]          event_count_o
);

    localparam int NUM_BYTES = nbytes(NUM_CH, BYTES_PER_CH, HDR_BYTES);
    localparam int CNT_W     = $clog2(NUM_BYTES);
    localparam int CB_W      = $clog2(BYTES_PER_CH);
    localparam int TO_W      = $clog2(TIMEOUT + 1);
    localparam bit RAMP      = (FAKE_MODE == FAKE_RAMP);

    state_t               r_state;
    logic                 r_mask_l;
    logic [CNT_W-1:0]     r_cnt;
    logic [CB_W-1:0]      r_cb;
    logic [1:0]           r_ph;
    logic [11:0]          r_samp;
    logic [TO_W-1:0]      r_idle;
    logic [HOLDOFF_W:0]   r_ho;
    logic [TRIG_W-1:0]    r_trig_cnt;
    logic [2:0]           r_err;
    logic [31:0]          r_evt;
    logic                 r_wr_en;
    logic [9:0]           r_wr_word;

    logic                 w_start;
    logic                 w_wr;
    logic                 w_user;
    logic                 w_last;
    logic                 w_hdr;
    logic [11:0]          w_s1;
    logic [7:0]           w_fake;
    logic [7:0]           w_data;
    logic                 w_timeout;
    logic                 w_dec;
    logic                 w_sat;
    logic                 w_ovf;
    logic [2:0]           w_new_err;
    logic [9:0]           w_rd_word;

    always_comb begin
        w_start = (r_state == IDLE) &&
                  (mask_i ? (r_trig_cnt != '0) : (s_dout_tvalid && s_dout_tdata[7]));
        // The first byte is taken in IDLE so it can sit ahead of the one-cycle START.
        w_wr    = w_start ||
                  ((r_state == COUNT) && (r_mask_l ? holdoff_ce_i : s_dout_tvalid)) ||
                  (r_state == PAD);
        w_user  = (r_state == IDLE) ? mask_i : r_mask_l;
        w_last  = (r_state != IDLE) && (r_cnt == CNT_W'(NUM_BYTES - 1));
        w_hdr   = (r_cnt < CNT_W'(HDR_BYTES));
        w_s1    = r_samp + 12'd1;
        w_fake  = '0;
        if (RAMP && !w_hdr) begin
            case (r_ph)
                2'd0:    w_fake = r_samp[7:0];
                2'd1:    w_fake = {w_s1[3:0], r_samp[11:8]};
                default: w_fake = w_s1[11:4];
            endcase
        end
        if (r_state == PAD) begin
            w_data = '0;
        end else if (w_user) begin
            w_data = w_fake;
        end else begin
            w_data = s_dout_tdata;
        end
        w_timeout = (r_state == COUNT) && !r_mask_l && !s_dout_tvalid &&
                    (r_idle == TO_W'(TIMEOUT - 1));
        w_dec     = (r_state == START) && r_mask_l;
        w_sat     = mask_i && trig_i && !w_dec && (r_trig_cnt == '1);
        w_new_err = '0;
        w_new_err[ERR_OVF] = w_ovf;
        w_new_err[ERR_SAT] = w_sat;
        w_new_err[ERR_TMO] = w_timeout;
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mask_l   <= 1'b0;
            r_cnt      <= '0;
            r_cb       <= '0;
            r_ph       <= '0;
            r_samp     <= '0;
            r_idle     <= '0;
            r_ho       <= '0;
            r_trig_cnt <= '0;
            r_err      <= '0;
            r_evt      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_word  <= '0;
        end else begin
            r_wr_en   <= w_wr;
            r_wr_word <= {w_user, w_last, w_data};

            if (w_wr) begin
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                if (!w_hdr) begin
                    if (r_cb == CB_W'(BYTES_PER_CH - 1)) begin
                        r_cb   <= '0;
                        r_ph   <= '0;
                        r_samp <= '0;
                    end else begin
                        r_cb <= r_cb + CB_W'(1);
                        if (r_ph == 2'd2) begin
                            r_ph   <= '0;
                            r_samp <= r_samp + 12'd2;
                        end else begin
                            r_ph <= r_ph + 2'd1;
                        end
                    end
                end
                if (w_last) begin
                    r_evt <= r_evt + 32'd1;
                end
            end

            if ((r_state == COUNT) && !s_dout_tvalid) begin
                r_idle <= r_idle + TO_W'(1);
            end else begin
                r_idle <= '0;
            end

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_mask_l <= mask_i;
                        r_cb     <= '0;
                        r_ph     <= '0;
                        r_samp   <= '0;
                        r_state  <= START;
                    end
                end
                START: r_state <= COUNT;
                COUNT: begin
                    if (w_wr && w_last) begin
                        r_ho    <= {1'b0, rdholdoff_i};
                        r_state <= HOLDOFF;
                    end else if (w_timeout) begin
                        r_state <= PAD;
                    end
                end
                PAD: begin
                    if (w_last) begin
                        r_ho    <= {1'b0, rdholdoff_i};
                        r_state <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (r_ho[HOLDOFF_W]) begin
                        r_state <= IDLE;
                    end else if (holdoff_ce_i) begin
                        r_ho <= r_ho - (HOLDOFF_W+1)'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (!mask_i) begin
                r_trig_cnt <= '0;
            end else if (trig_i && !w_dec) begin
                if (r_trig_cnt != '1) begin
                    r_trig_cnt <= r_trig_cnt + TRIG_W'(1);
                end
            end else if (w_dec && !trig_i && (r_trig_cnt != '0)) begin
                r_trig_cnt <= r_trig_cnt - TRIG_W'(1);
            end

            r_err <= (err_clr_i ? '0 : r_err) | w_new_err;
        end
    end

    splice_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (10)
    ) u_fifo (
        .clk       (aclk),
        .rst       (rst),
        .i_wr_en   (r_wr_en),
        .i_wr_data (r_wr_word),
        .i_rd_en   (m_dout_tready),
        .o_rd_data (w_rd_word),
        .o_valid   (m_dout_tvalid),
        .o_ovf     (w_ovf)
    );

    always_comb begin
        m_dout_tdata  = w_rd_word[7:0];
        m_dout_tlast  = w_rd_word[8];
        m_dout_tuser  = w_rd_word[9];
        err_o         = r_err;
        event_count_o = r_evt;
    end

endmodule
